// File: rtl/repair_solution_checker.sv
// Repair-solution checker: stores captured faults and evaluates streamed DSSS/RLSS
// candidates in a 2-stage pipeline, reporting the first one that covers every fault.
module repair_solution_checker #(
  parameter int ROW_W      = 10,
  parameter int COL_W      = 10,
  parameter int MAX_FAULTS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       spare_struct_type,
  input  logic             flt_wr,
  input  logic [ROW_W-1:0] flt_row,
  input  logic [COL_W-1:0] flt_col,
  input  logic             flt_clr,
  input  logic             start,
  input  logic [7:0]       DSSS,
  input  logic [3:0]       RLSS,
  input  logic             gen_sig,
  output logic             busy,
  output logic             repair_done,
  output logic             repairable,
  output logic [7:0]       sol_dsss,
  output logic [3:0]       sol_rlss,
  output logic [4:0]       fault_cnt,
  output logic             fault_overflow
);

  localparam int IDX_W = $clog2(MAX_FAULTS);
  localparam logic [4:0] MAX_CNT = 5'(MAX_FAULTS);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} stateT;

  stateT                 state_q, state_d;
  logic [4:0]            faultCnt_q, faultCnt_d;
  logic                  overflow_q, overflow_d;
  logic                  repairDone_q, repairDone_d;
  logic                  repairable_q, repairable_d;
  logic [7:0]            solDsss_q, solDsss_d;
  logic [3:0]            solRlss_q, solRlss_d;
  logic                  wrEn;

  logic [ROW_W-1:0]      rowMem [MAX_FAULTS];
  logic [COL_W-1:0]      colMem [MAX_FAULTS];

  logic [MAX_FAULTS-1:0] cover_d, storedMask;
  logic [MAX_FAULTS-1:0] s1Cover_q;
  logic [7:0]            s1Dsss_q, s2Dsss_q;
  logic [3:0]            s1Rlss_q, s2Rlss_q;
  logic                  s1Valid_q, s1Last_q, s2Valid_q, s2Last_q, s2Ok_q;
  logic                  genPrev_q;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      rowMem[faultCnt_q[IDX_W-1:0]] <= flt_row;
      colMem[faultCnt_q[IDX_W-1:0]] <= flt_col;
    end
  end

  // A fault is covered when some present pivot's chosen line (row or column) passes through it.
  always_comb begin
    cover_d    = '0;
    storedMask = '0;
    for (int f = 0; f < MAX_FAULTS; f++) begin
      storedMask[f] = (5'(f) < faultCnt_q);
      for (int i = 0; i < 8; i++) begin
        if (5'(i) < faultCnt_q) begin
          if (DSSS[i] ? (rowMem[f] == rowMem[i]) : (colMem[f] == colMem[i]))
            cover_d[f] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Cover_q <= '0;
      s1Dsss_q  <= '0;
      s1Rlss_q  <= '0;
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s2Dsss_q  <= '0;
      s2Rlss_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      s2Ok_q    <= 1'b0;
      genPrev_q <= 1'b0;
    end else if (state_q != SEARCH) begin
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      genPrev_q <= 1'b0;
    end else begin
      s1Cover_q <= cover_d;
      s1Dsss_q  <= DSSS;
      s1Rlss_q  <= (spare_struct_type == 2'b11) ? RLSS : 4'h0;
      s1Valid_q <= (DSSS != 8'h00);
      s1Last_q  <= genPrev_q && !gen_sig;
      genPrev_q <= gen_sig;
      s2Dsss_q  <= s1Dsss_q;
      s2Rlss_q  <= s1Rlss_q;
      s2Valid_q <= s1Valid_q;
      s2Last_q  <= s1Last_q;
      s2Ok_q    <= &(s1Cover_q | ~storedMask);
    end
  end

  // Control: flt_clr overrides everything; a success in stage 2 wins over an end-of-sequence mark.
  always_comb begin
    state_d      = state_q;
    faultCnt_d   = faultCnt_q;
    overflow_d   = overflow_q;
    repairDone_d = repairDone_q;
    repairable_d = repairable_q;
    solDsss_d    = solDsss_q;
    solRlss_d    = solRlss_q;
    wrEn         = 1'b0;
    if (flt_clr) begin
      faultCnt_d   = '0;
      overflow_d   = 1'b0;
      repairDone_d = 1'b0;
      repairable_d = 1'b0;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == IDLE && flt_wr) begin
            if (faultCnt_q == MAX_CNT) begin
              overflow_d = 1'b1;
            end else begin
              wrEn       = 1'b1;
              faultCnt_d = faultCnt_q + 5'd1;
            end
          end
          if (start) begin
            repairDone_d = 1'b0;
            repairable_d = 1'b0;
            solDsss_d    = '0;
            solRlss_d    = '0;
            if (faultCnt_q == 5'd0) begin
              repairDone_d = 1'b1;
              repairable_d = 1'b1;
              state_d      = DONE;
            end else if (overflow_q || spare_struct_type == 2'b00) begin
              repairDone_d = 1'b1;
              state_d      = DONE;
            end else begin
              state_d = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (s2Valid_q && s2Ok_q) begin
            solDsss_d    = s2Dsss_q;
            solRlss_d    = s2Rlss_q;
            repairable_d = 1'b1;
            repairDone_d = 1'b1;
            state_d      = DONE;
          end else if (s2Last_q) begin
            repairable_d = 1'b0;
            repairDone_d = 1'b1;
            state_d      = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      faultCnt_q   <= '0;
      overflow_q   <= 1'b0;
      repairDone_q <= 1'b0;
      repairable_q <= 1'b0;
      solDsss_q    <= '0;
      solRlss_q    <= '0;
    end else begin
      state_q      <= state_d;
      faultCnt_q   <= faultCnt_d;
      overflow_q   <= overflow_d;
      repairDone_q <= repairDone_d;
      repairable_q <= repairable_d;
      solDsss_q    <= solDsss_d;
      solRlss_q    <= solRlss_d;
    end
  end

  assign busy           = (state_q == SEARCH);
  assign repair_done    = repairDone_q;
  assign repairable     = repairable_q;
  assign sol_dsss       = solDsss_q;
  assign sol_rlss       = solRlss_q;
  assign fault_cnt      = faultCnt_q;
  assign fault_overflow = overflow_q;

endmodule

// File: tb/tb_repair_solution_checker.sv
// Directed bench for repair_solution_checker: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_repair_solution_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] spare_struct_type = 2'b00;
  logic       flt_wr = 1'b0;
  logic [9:0] flt_row = '0;
  logic [9:0] flt_col = '0;
  logic       flt_clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] DSSS = '0;
  logic [3:0] RLSS = '0;
  logic       gen_sig = 1'b0;
  logic       busy, repair_done, repairable, fault_overflow;
  logic [7:0] sol_dsss;
  logic [3:0] sol_rlss;
  logic [4:0] fault_cnt;

  int vectors = 0;
  int miscompares = 0;

  repair_solution_checker #(.ROW_W(10), .COL_W(10), .MAX_FAULTS(16)) dut (
    .clk(clk), .rst(rst), .spare_struct_type(spare_struct_type),
    .flt_wr(flt_wr), .flt_row(flt_row), .flt_col(flt_col), .flt_clr(flt_clr),
    .start(start), .DSSS(DSSS), .RLSS(RLSS), .gen_sig(gen_sig),
    .busy(busy), .repair_done(repair_done), .repairable(repairable),
    .sol_dsss(sol_dsss), .sol_rlss(sol_rlss), .fault_cnt(fault_cnt),
    .fault_overflow(fault_overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeFault(input int r, input int c);
    flt_wr = 1'b1; flt_row = 10'(r); flt_col = 10'(c);
    tick();
    flt_wr = 1'b0;
  endtask

  task automatic clearFaults();
    flt_clr = 1'b1;
    tick();
    flt_clr = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({busy, repair_done, repairable, sol_dsss, sol_rlss, fault_cnt, fault_overflow} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {busy, repair_done, repairable, sol_dsss, sol_rlss, fault_cnt, fault_overflow});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_s1_diagonal();
    for (int k = 1; k <= 5; k++) writeFault(k, k);
    vectors++;
    if (fault_cnt !== 5'd5) begin miscompares++; $display("[TB] FAIL diag_cnt: got %0d expected 5", fault_cnt); end
    spare_struct_type = 2'b01;
    pulseStart();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL diag_busy: got %b expected 1", busy); end
    gen_sig = 1'b1; RLSS = 4'hF;
    DSSS = 8'h00; tick();
    DSSS = 8'h0F; tick();
    DSSS = 8'hF0; tick();
    vectors++;
    if (repair_done !== 1'b0) begin miscompares++; $display("[TB] FAIL diag_early_done: got %b expected 0", repair_done); end
    DSSS = 8'h33; tick();
    vectors++;
    if ({repair_done, repairable, busy} !== 3'b110) begin
      miscompares++; $display("[TB] FAIL diag_verdict: got %b expected 110", {repair_done, repairable, busy});
    end
    vectors++;
    if (sol_dsss !== 8'h0F || sol_rlss !== 4'h0) begin
      miscompares++; $display("[TB] FAIL diag_sol: got %h/%h expected 0f/0", sol_dsss, sol_rlss);
    end
    gen_sig = 1'b0; DSSS = 8'h00; tick();
    vectors++;
    if (sol_dsss !== 8'h0F) begin miscompares++; $display("[TB] FAIL diag_hold: got %h expected 0f", sol_dsss); end
  endtask

  task automatic test_coverage();
    clearFaults();
    for (int k = 1; k <= 8; k++) writeFault(k, k);
    writeFault(1, 50);
    spare_struct_type = 2'b10;
    pulseStart();
    gen_sig = 1'b1;
    DSSS = 8'hFE; tick();
    DSSS = 8'h01; tick();
    DSSS = 8'hFF; tick();
    vectors++;
    if (repair_done !== 1'b0) begin miscompares++; $display("[TB] FAIL cov_reject: got %b expected 0", repair_done); end
    DSSS = 8'h00; tick();
    vectors++;
    if ({repair_done, repairable} !== 2'b11 || sol_dsss !== 8'h01) begin
      miscompares++; $display("[TB] FAIL cov_accept: got %b/%h expected 11/01", {repair_done, repairable}, sol_dsss);
    end
    gen_sig = 1'b0; tick();
  endtask

  task automatic test_fail_sequence();
    clearFaults();
    for (int k = 1; k <= 9; k++) writeFault(k, k);
    vectors++;
    if (fault_cnt !== 5'd9) begin miscompares++; $display("[TB] FAIL fail_cnt: got %0d expected 9", fault_cnt); end
    spare_struct_type = 2'b10;
    pulseStart();
    gen_sig = 1'b1;
    DSSS = 8'hFF; tick();
    DSSS = 8'h0F; tick();
    gen_sig = 1'b0; DSSS = 8'h55; tick();
    DSSS = 8'h00; tick();
    vectors++;
    if ({repair_done, busy} !== 2'b01) begin
      miscompares++; $display("[TB] FAIL fail_early: got %b expected 01", {repair_done, busy});
    end
    tick();
    vectors++;
    if ({repair_done, repairable, busy} !== 3'b100) begin
      miscompares++; $display("[TB] FAIL fail_verdict: got %b expected 100", {repair_done, repairable, busy});
    end
  endtask

  task automatic test_zero_faults();
    clearFaults();
    spare_struct_type = 2'b01;
    pulseStart();
    vectors++;
    if ({repair_done, repairable, busy} !== 3'b110 || sol_dsss !== 8'h00) begin
      miscompares++; $display("[TB] FAIL zero_verdict: got %b/%h expected 110/00", {repair_done, repairable, busy}, sol_dsss);
    end
  endtask

  task automatic test_overflow();
    clearFaults();
    for (int k = 0; k < 17; k++) writeFault(k + 20, k + 40);
    vectors++;
    if (fault_cnt !== 5'd16 || fault_overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL ovf_store: got %0d/%b expected 16/1", fault_cnt, fault_overflow);
    end
    pulseStart();
    vectors++;
    if ({repair_done, repairable, busy} !== 3'b100) begin
      miscompares++; $display("[TB] FAIL ovf_verdict: got %b expected 100", {repair_done, repairable, busy});
    end
    clearFaults();
    vectors++;
    if (fault_cnt !== 5'd0 || fault_overflow !== 1'b0 || repair_done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ovf_clear: got %0d/%b/%b expected 0/0/0", fault_cnt, fault_overflow, repair_done);
    end
  endtask

  task automatic test_s3_rlss();
    clearFaults();
    spare_struct_type = 2'b11;
    writeFault(7, 0); writeFault(7, 1); writeFault(7, 2);
    pulseStart();
    gen_sig = 1'b1;
    DSSS = 8'h06; RLSS = 4'hA; tick();
    DSSS = 8'h00; RLSS = 4'h5; tick();
    tick();
    vectors++;
    if ({repair_done, repairable} !== 2'b11 || sol_rlss !== 4'hA) begin
      miscompares++; $display("[TB] FAIL s3_rlss: got %b/%h expected 11/a", {repair_done, repairable}, sol_rlss);
    end
    vectors++;
    if (sol_dsss !== 8'h06) begin miscompares++; $display("[TB] FAIL s3_dsss: got %h expected 06", sol_dsss); end
    gen_sig = 1'b0; tick();
  endtask

  task automatic test_reset_mid_search();
    clearFaults();
    spare_struct_type = 2'b01;
    writeFault(3, 4); writeFault(5, 6);
    pulseStart();
    DSSS = 8'h00; gen_sig = 1'b0;
    writeFault(9, 9);
    vectors++;
    if (fault_cnt !== 5'd2 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL search_wr_ignored: got %0d/%b expected 2/1", fault_cnt, busy);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, repair_done, repairable, sol_dsss, sol_rlss, fault_cnt, fault_overflow} !== 22'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected 0",
               {busy, repair_done, repairable, sol_dsss, sol_rlss, fault_cnt, fault_overflow});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_s1_diagonal();
    test_coverage();
    test_fail_sequence();
    test_zero_faults();
    test_overflow();
    test_s3_rlss();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
